// File: rtl/control_sequencer_pkg.sv
// Shared CPU control definitions: opcodes, step-state encodings and opcode classes.
package cpu_defs;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        T6     = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_MULDIV = 3'd1,
        CL_MFHI   = 3'd2,
        CL_MFLO   = 3'd3,
        CL_NOP    = 3'd4,
        CL_HALT   = 3'd5
    } op_class_t;

endpackage

// File: rtl/control_sequencer_op_class_decode.sv
// Combinational opcode-to-class map; anything unrecognised behaves as a nop.
module op_class_decode
    import cpu_defs::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] op_i,
    output op_class_t      cls_o
);

    always_comb begin
        cls_o = CL_NOP;
        case (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  cls_o = CL_ALU;
            OP_DIV, OP_MUL:                   cls_o = CL_MULDIV;
            OP_MFHI:                          cls_o = CL_MFHI;
            OP_MFLO:                          cls_o = CL_MFLO;
            OP_HALT:                          cls_o = CL_HALT;
            OP_NOP:                           cls_o = CL_NOP;
            default:                          cls_o = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, then class-dependent execute steps.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int OPW      = 5,
    parameter int NSTATE_W = 4
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [OPW-1:0] ir_op,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           RZin,
    output logic           RZLOout,
    output logic           RZHIout,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           gra,
    output logic           grb,
    output logic           grc,
    output logic           rin,
    output logic           rout,
    output logic           BAout,
    output logic           RYin,
    output logic           HIin,
    output logic           LOin,
    output logic           HIout,
    output logic           LOout,
    output logic [OPW-1:0] ops,
    output logic           run
);

    logic [NSTATE_W-1:0] state_q, state_d;
    op_class_t           cls;

    op_class_decode #(.OPW(OPW)) u_decode (
        .op_i  (ir_op),
        .cls_o (cls)
    );

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_RST;
        else       state_q <= state_d;
    end

    assign BAout = 1'b0;

    always_comb begin
        state_d = S_RST;
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; RZin = 1'b0;
        RZLOout = 1'b0; RZHIout = 1'b0; PCin = 1'b0; Read = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
        RYin = 1'b0; HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        ops = '0;
        run = 1'b1;
        case (state_q)
            S_RST: state_d = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
                state_d = T1;
            end
            T1: begin
                RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_d = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = T3;
            end
            T3: begin
                state_d = T0;
                case (cls)
                    CL_ALU:    begin grb = 1'b1; rout = 1'b1; RYin = 1'b1; state_d = T4; end
                    CL_MULDIV: begin gra = 1'b1; rout = 1'b1; RYin = 1'b1; state_d = T4; end
                    CL_MFHI:   begin gra = 1'b1; rin = 1'b1; HIout = 1'b1; end
                    CL_MFLO:   begin gra = 1'b1; rin = 1'b1; LOout = 1'b1; end
                    CL_HALT:   state_d = S_HALT;
                    default:   state_d = T0;
                endcase
            end
            // Execute steps beyond T3 only exist for ALU and MULDIV; a stray class returns to fetch.
            T4: begin
                state_d = T0;
                if (cls == CL_ALU) begin
                    grc = 1'b1; rout = 1'b1; RZin = 1'b1; ops = ir_op; state_d = T5;
                end else if (cls == CL_MULDIV) begin
                    grb = 1'b1; rout = 1'b1; RZin = 1'b1; ops = ir_op; state_d = T5;
                end
            end
            T5: begin
                state_d = T0;
                if (cls == CL_ALU) begin
                    RZLOout = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (cls == CL_MULDIV) begin
                    RZLOout = 1'b1; LOin = 1'b1; state_d = T6;
                end
            end
            T6: begin
                RZHIout = 1'b1; HIin = 1'b1;
                state_d = T0;
            end
            S_HALT: begin
                run = 1'b0;
                state_d = S_HALT;
            end
            default: state_d = S_RST;
        endcase
    end

    a_bus_onehot: assert property (@(posedge clock) disable iff (clear)
        $onehot0({PCout, RZLOout, RZHIout, MDRout, HIout, LOout, rout}));
    a_gr_onehot: assert property (@(posedge clock) disable iff (clear)
        $onehot0({gra, grb, grc}));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected strobe words queued, checked by a negedge monitor.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       clear;
    logic [4:0] ir_op;
    logic PCout, MARin, IncPC, RZin, RZLOout, RZHIout, PCin, Read, MDRin, MDRout, IRin;
    logic gra, grb, grc, rin, rout, BAout, RYin, HIin, LOin, HIout, LOout, run;
    logic [4:0] ops;

    control_sequencer #(.OPW(5), .NSTATE_W(4)) dut (
        .clock(clock), .clear(clear), .ir_op(ir_op),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin),
        .RZLOout(RZLOout), .RZHIout(RZHIout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .BAout(BAout),
        .RYin(RYin), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .ops(ops), .run(run)
    );

    always #5 clock = ~clock;

    localparam logic [27:0] B_PCOUT   = 28'd1 << 0;
    localparam logic [27:0] B_MARIN   = 28'd1 << 1;
    localparam logic [27:0] B_INCPC   = 28'd1 << 2;
    localparam logic [27:0] B_RZIN    = 28'd1 << 3;
    localparam logic [27:0] B_RZLOOUT = 28'd1 << 4;
    localparam logic [27:0] B_RZHIOUT = 28'd1 << 5;
    localparam logic [27:0] B_PCIN    = 28'd1 << 6;
    localparam logic [27:0] B_READ    = 28'd1 << 7;
    localparam logic [27:0] B_MDRIN   = 28'd1 << 8;
    localparam logic [27:0] B_MDROUT  = 28'd1 << 9;
    localparam logic [27:0] B_IRIN    = 28'd1 << 10;
    localparam logic [27:0] B_GRA     = 28'd1 << 11;
    localparam logic [27:0] B_GRB     = 28'd1 << 12;
    localparam logic [27:0] B_GRC     = 28'd1 << 13;
    localparam logic [27:0] B_RIN     = 28'd1 << 14;
    localparam logic [27:0] B_ROUT    = 28'd1 << 15;
    localparam logic [27:0] B_RYIN    = 28'd1 << 17;
    localparam logic [27:0] B_HIIN    = 28'd1 << 18;
    localparam logic [27:0] B_LOIN    = 28'd1 << 19;
    localparam logic [27:0] B_HIOUT   = 28'd1 << 20;
    localparam logic [27:0] B_LOOUT   = 28'd1 << 21;
    localparam logic [27:0] B_RUN     = 28'd1 << 27;

    localparam logic [27:0] E_RST  = B_RUN;
    localparam logic [27:0] E_HALT = 28'd0;
    localparam logic [27:0] E_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_RZIN;
    localparam logic [27:0] E_T1   = B_RUN | B_RZLOOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [27:0] E_T2   = B_RUN | B_MDROUT | B_IRIN;

    typedef struct {
        logic [27:0] w;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [27:0] act;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;

    assign act = {run, ops, LOout, HIout, LOin, HIin, RYin, BAout, rout, rin, grc, grb, gra,
                  IRin, MDRout, MDRin, Read, PCin, RZHIout, RZLOout, RZin, IncPC, MARin, PCout};

    always @(negedge clock) begin
        cyc_n <= cyc_n + 1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if (act !== e.w) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got %h expected %h", e.tag, cyc_n, act, e.w);
            end
        end
    end

    // Expect w for the current cycle; inputs set before the call steer the next edge.
    task automatic cyc(input logic [27:0] w, input string tag);
        exp_t x;
        x.w = w;
        x.tag = tag;
        sb_q.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string p);
        cyc(E_T0, {p, "_T0"});
        cyc(E_T1, {p, "_T1"});
        cyc(E_T2, {p, "_T2"});
    endtask

    initial begin
        clear = 1'b1;
        ir_op = 5'b11111;
        @(posedge clock);
        #1;
        cyc(E_RST, "rst_a");
        clear = 1'b0;
        cyc(E_RST, "rst_b");

        ir_op = 5'b11001;
        fetch("mfhi");
        cyc(B_RUN | B_GRA | B_RIN | B_HIOUT, "mfhi_T3");

        ir_op = 5'b11011;
        cyc(E_T0, "add_T0");
        ir_op = 5'b10000;
        cyc(E_T1, "add_T1");
        ir_op = 5'b00011;
        cyc(E_T2, "add_T2");
        cyc(B_RUN | B_GRB | B_ROUT | B_RYIN, "add_T3");
        cyc(B_RUN | B_GRC | B_ROUT | B_RZIN | {1'b0, 5'b00011, 22'd0}, "add_T4");
        cyc(B_RUN | B_RZLOOUT | B_GRA | B_RIN, "add_T5");

        ir_op = 5'b10000;
        fetch("mul");
        cyc(B_RUN | B_GRA | B_ROUT | B_RYIN, "mul_T3");
        cyc(B_RUN | B_GRB | B_ROUT | B_RZIN | {1'b0, 5'b10000, 22'd0}, "mul_T4");
        cyc(B_RUN | B_RZLOOUT | B_LOIN, "mul_T5");
        cyc(B_RUN | B_RZHIOUT | B_HIIN, "mul_T6");

        ir_op = 5'b00111;
        fetch("ror");
        cyc(B_RUN | B_GRB | B_ROUT | B_RYIN, "ror_T3");
        cyc(B_RUN | B_GRC | B_ROUT | B_RZIN | {1'b0, 5'b00111, 22'd0}, "ror_T4");
        cyc(B_RUN | B_RZLOOUT | B_GRA | B_RIN, "ror_T5");

        ir_op = 5'b01111;
        fetch("div");
        cyc(B_RUN | B_GRA | B_ROUT | B_RYIN, "div_T3");
        cyc(B_RUN | B_GRB | B_ROUT | B_RZIN | {1'b0, 5'b01111, 22'd0}, "div_T4");
        cyc(B_RUN | B_RZLOOUT | B_LOIN, "div_T5");
        cyc(B_RUN | B_RZHIOUT | B_HIIN, "div_T6");

        ir_op = 5'b11000;
        fetch("mflo");
        cyc(B_RUN | B_GRA | B_RIN | B_LOOUT, "mflo_T3");

        ir_op = 5'b11010;
        fetch("nop");
        cyc(E_RST, "nop_T3");

        ir_op = 5'b00000;
        fetch("undef");
        cyc(E_RST, "undef_T3");

        ir_op = 5'b11011;
        fetch("halt");
        cyc(E_RST, "halt_T3");
        for (int i = 0; i < 19; i++) begin
            ir_op = 5'(i * 7);
            cyc(E_HALT, "halted");
        end
        clear = 1'b1;
        cyc(E_HALT, "halted_last");
        clear = 1'b0;
        cyc(E_RST, "halt_clear");

        ir_op = 5'b10000;
        fetch("mulclr");
        cyc(B_RUN | B_GRA | B_ROUT | B_RYIN, "mulclr_T3");
        cyc(B_RUN | B_GRB | B_ROUT | B_RZIN | {1'b0, 5'b10000, 22'd0}, "mulclr_T4");
        clear = 1'b1;
        cyc(B_RUN | B_RZLOOUT | B_LOIN, "mulclr_T5");
        clear = 1'b0;
        ir_op = 5'b11111;
        cyc(E_RST, "mulclr_rst");
        fetch("op1f");
        cyc(E_RST, "op1f_T3");
        cyc(E_T0, "op1f_next_T0");

        @(negedge clock);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that generates the per-step DataPath control strobes that benches currently drive by hand.
- Runs instruction fetch (T0-T2), then decodes the 5-bit opcode from IR[31:27] and sequences execute steps for:
  - register-register ALU ops
  - mul/div
  - mfhi/mflo
  - nop/halt
- Sits beside DataPath; drives its control inputs from a single step-state register.

Parameters:
- OPW, 5, opcode / ALU-select width
- NSTATE_W, 4, state register width

Ports:
- clock  in  1  system clock; all state changes on posedge
- clear  in  1  synchronous active-high reset
- ir_op  in  5  IR[31:27] from DataPath, valid from T3 onward
- PCout, MARin, IncPC, RZin, RZLOout, RZHIout, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch/ALU transfer strobes
- gra, grb, grc, rin, rout, BAout  out  1 each  select-and-encode strobes
- RYin, HIin, LOin, HIout, LOout  out  1 each  Y/HI/LO strobes
- ops  out  5  ALU operation select
- run  out  1  high unless halted

Behaviour:
- Moore machine: every output is decoded from the state register only, except ops and the T3-T6 branch, which also use ir_op. No output depends combinationally on clear.
- Reset:
  - clear is sampled at posedge; state <= S_RST in any state, including mid-instruction.
  - In S_RST all strobes are 0, ops = 0 and run = 1.
  - S_RST -> T0 on the first edge with clear low.
- Fetch (all opcodes):
  - T0: PCout, MARin, IncPC, RZin
  - T1: RZLOout, PCin, Read, MDRin
  - T2: MDRout, IRin
  - T2 -> T3 unconditionally.
- ALU class (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: grb, rout, RYin
  - T4: grc, rout, RZin, ops = ir_op
  - T5: RZLOout, gra, rin
  - Then -> T0. Total 6 cycles.
- MULDIV class (div 01111, mul 10000):
  - T3: gra, rout, RYin
  - T4: grb, rout, RZin, ops = ir_op
  - T5: RZLOout, LOin
  - T6: RZHIout, HIin
  - Then -> T0. Total 7 cycles.
- mfhi 11001: T3 asserts gra, rin, HIout, then -> T0.
- mflo 11000: T3 asserts gra, rin, LOout, then -> T0.
- nop 11010, and every opcode not listed here: T3 asserts no strobes, then -> T0.
- halt 11011:
  - T3 asserts no strobes, then -> S_HALT.
  - S_HALT: all strobes 0, run = 0; only clear exits.
- ops = 0 in every state except ALU/MULDIV T4.
- Exclusivity invariants (verify by assertion):
  - At most one of {PCout, RZLOout, RZHIout, MDRout, HIout, LOout, rout} is high in any cycle.
  - At most one of gra/grb/grc is high in any cycle.
- BAout is reserved and tied 0 in this revision.
- ir_op is ignored in T0-T2 and S_HALT; changes to it there have no effect.
- Unused state encodings -> S_RST on the next edge.

Decomposition:
- Shared package cpu_defs holds:
  - opcode localparams (OP_ADD ... OP_HALT)
  - state encodings S_RST, T0-T6, S_HALT
  - class enum CL_ALU, CL_MULDIV, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
- One sub-module, op_class_decode: combinational map from ir_op to class, shared later with the branch/load-store extension.
- The sequencer keeps the state register and the strobe decode.

Test Plan:
- clear high for 2 edges then low:
  - all strobes 0 and run = 1 during reset
  - first cycle after release is T0 with PCout = MARin = IncPC = RZin = 1
  - then T1 (RZLOout, PCin, Read, MDRin = 1), then T2 (MDRout, IRin = 1)
- ir_op = 11001 (mfhi): T3 has gra = rin = HIout = 1 for exactly one cycle, every other strobe 0; the following cycle is T0.
- ir_op = 00011 (add): T3 grb/rout/RYin; T4 grc/rout/RZin with ops = 00011; T5 RZLOout/gra/rin; next fetch starts 6 cycles after the previous T0.
- ir_op = 10000 (mul): T5 LOin = 1 with RZLOout; T6 HIin = 1 with RZHIout; next T0 occurs 7 cycles after the previous T0.
- ir_op = 11011 (halt):
  - run falls to 0 the cycle after T3 and stays 0 for 20 cycles with all strobes 0
  - clear restores run = 1 and T0 follows
- clear asserted during MULDIV T5:
  - next cycle is S_RST, so HIin never pulses
  - ir_op = 11111 runs as nop (fetch + a T3 with no strobes, back to T0)
